// File: rtl/nib_fifo_drain.sv
// rtl/nib_fifo_drain.sv - drain controller for the flushable nibble FIFO
module nib_fifo_drain #(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_data_avail_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_valid_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic              fifo_flush_o,
  input  logic              fifo_flush_done_i,
  input  logic              flush_req_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [7:0]        flush_cnt_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              flush_q;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] d0_q, d1_q;
  logic              l0_q, l1_q;
  logic              push, pop, idle_partial;

  // Reads never look at m_ready_i: a full queue simply stops pulling words.
  assign pop          = (count_q != 2'd0) && m_ready_i;
  assign push         = fifo_data_avail_i && (count_q != 2'd2);
  assign idle_partial = !fifo_empty_i && !fifo_data_avail_i;

  assign fifo_rd_valid_o = push;
  assign m_valid_o       = (count_q != 2'd0);
  assign m_data_o        = d0_q;
  assign m_last_o        = l0_q;
  assign fifo_flush_o    = flush_q;
  assign flush_cnt_o     = cnt_q;

  // Next-state logic: idle timer, flush triggers and the saturating flush counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_partial) begin
          if (timer_q == TMO_LAST) begin
            state_d = FLUSH;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end else begin
          timer_d = 8'd0;
        end
        // A request coinciding with the timeout still lands in the same single FLUSH.
        if (flush_req_i && !fifo_empty_i) begin
          state_d = FLUSH;
          timer_d = 8'd0;
        end
      end
      FLUSH: begin
        timer_d = 8'd0;
        if (fifo_flush_done_i) begin
          state_d = IDLE;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 8'd0;
      end
    endcase
  end

  // Control registers; the flush request is registered off the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      cnt_q   <= 8'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      flush_q <= (state_d == FLUSH);
    end
  end

  // Two-entry output queue; entry 0 is always the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      d0_q    <= '0;
      d1_q    <= '0;
      l0_q    <= 1'b0;
      l1_q    <= 1'b0;
    end else begin
      if (push && pop) begin
        d0_q <= fifo_rd_data_i;
        l0_q <= fifo_flush_done_i;
      end else if (push) begin
        if (count_q == 2'd0) begin
          d0_q <= fifo_rd_data_i;
          l0_q <= fifo_flush_done_i;
        end else begin
          d1_q <= fifo_rd_data_i;
          l1_q <= fifo_flush_done_i;
        end
        count_q <= count_q + 2'd1;
      end else if (pop) begin
        if (count_q == 2'd2) begin
          d0_q <= d1_q;
          l0_q <= l1_q;
        end
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule
